// File: rtl/bellek_hakemi_pkg.sv
// Shared constants for the two-requester memory port arbiter:
// state encoding, requester indices and default bus widths.
package bellek_hakemi_pkg;

    // FSM state encoding
    localparam logic [1:0] BOSTA  = 2'd0;
    localparam logic [1:0] ERISIM = 2'd1;
    localparam logic [1:0] YANIT  = 2'd2;

    // Requester indices: I0 is the core, I1 the loader/debug DMA
    localparam logic I0 = 1'b0;
    localparam logic I1 = 1'b1;

    // Default bus geometry and post-reset memory address
    localparam int          ADRES_BIT   = 32;
    localparam int          VERI_BIT    = 32;
    localparam logic [31:0] SIFIR_ADRES = 32'h8000_0000;

endpackage

// File: rtl/hakem_oncelik.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes
// to the requester that was not granted last.
module hakem_oncelik (
    input  logic [1:0] istek,
    input  logic       last_grant,
    output logic       gecerli,
    output logic       secilen
);
    import bellek_hakemi_pkg::*;

    // Pick the winner among the current requests
    always_comb begin
        gecerli = |istek;
        secilen = I0;
        if (istek == 2'b11) begin
            secilen = ~last_grant;
        end else if (istek[1]) begin
            secilen = I1;
        end
    end

endmodule

// File: rtl/bellek_hakemi.sv
// Shares one memory port between the core (i0) and the loader/DMA (i1).
// One transaction at a time: BOSTA samples requests, ERISIM drives the
// latched address/data for one cycle, YANIT waits out the read latency.
module bellek_hakemi #(
    parameter int                       ADRES_BIT   = bellek_hakemi_pkg::ADRES_BIT,
    parameter int                       VERI_BIT    = bellek_hakemi_pkg::VERI_BIT,
    parameter int                       OKU_GECIKME = 1,
    parameter logic [ADRES_BIT-1:0]     SIFIR_ADRES = ADRES_BIT'(bellek_hakemi_pkg::SIFIR_ADRES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i0_istek,
    input  logic [ADRES_BIT-1:0] i0_adres,
    input  logic                 i0_yaz,
    input  logic [VERI_BIT-1:0]  i0_yaz_veri,
    output logic                 i0_bitti,
    output logic [VERI_BIT-1:0]  i0_oku_veri,
    input  logic                 i1_istek,
    input  logic [ADRES_BIT-1:0] i1_adres,
    input  logic                 i1_yaz,
    input  logic [VERI_BIT-1:0]  i1_yaz_veri,
    output logic                 i1_bitti,
    output logic [VERI_BIT-1:0]  i1_oku_veri,
    output logic [ADRES_BIT-1:0] bellek_adres,
    output logic                 bellek_yaz,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    input  logic [VERI_BIT-1:0]  bellek_oku_veri
);
    import bellek_hakemi_pkg::*;

    // Read countdown start value; latency is limited to 1..3 so 2 bits suffice
    localparam logic [1:0] SAYAC_YUK = 2'(OKU_GECIKME - 1);

    logic [1:0]           state_reg;
    logic                 owner_reg;
    logic                 last_grant_reg;
    logic                 yaz_reg;
    logic [1:0]           sayac_reg;
    logic [ADRES_BIT-1:0] adres_reg;
    logic [VERI_BIT-1:0]  yaz_veri_reg;

    logic                 gecerli;
    logic                 secilen;
    logic                 yaz_bitti;
    logic                 oku_bitti;

    // Per-requester views so the grant mux and outputs can be generated
    logic [1:0]                istek_vec;
    logic [ADRES_BIT-1:0]      adres_arr    [2];
    logic                      yaz_arr      [2];
    logic [VERI_BIT-1:0]       yaz_veri_arr [2];
    logic [1:0]                bitti_vec;
    logic [VERI_BIT-1:0]       oku_veri_arr [2];

    assign istek_vec       = {i1_istek, i0_istek};
    assign adres_arr[0]    = i0_adres;
    assign adres_arr[1]    = i1_adres;
    assign yaz_arr[0]      = i0_yaz;
    assign yaz_arr[1]      = i1_yaz;
    assign yaz_veri_arr[0] = i0_yaz_veri;
    assign yaz_veri_arr[1] = i1_yaz_veri;

    hakem_oncelik u_oncelik (
        .istek      (istek_vec),
        .last_grant (last_grant_reg),
        .gecerli    (gecerli),
        .secilen    (secilen)
    );

    // Main FSM: grant, latch the winner's request, count out the read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= BOSTA;
            owner_reg      <= I0;
            last_grant_reg <= I1;
            yaz_reg        <= 1'b0;
            sayac_reg      <= 2'd0;
            adres_reg      <= SIFIR_ADRES;
            yaz_veri_reg   <= '0;
        end else begin
            case (state_reg)
                BOSTA: begin
                    if (gecerli) begin
                        owner_reg      <= secilen;
                        last_grant_reg <= secilen;
                        adres_reg      <= adres_arr[secilen];
                        yaz_reg        <= yaz_arr[secilen];
                        yaz_veri_reg   <= yaz_veri_arr[secilen];
                        state_reg      <= ERISIM;
                    end
                end
                ERISIM: begin
                    if (yaz_reg) begin
                        state_reg <= BOSTA;
                    end else begin
                        sayac_reg <= SAYAC_YUK;
                        state_reg <= YANIT;
                    end
                end
                YANIT: begin
                    if (sayac_reg == 2'd0) begin
                        state_reg <= BOSTA;
                    end else begin
                        sayac_reg <= sayac_reg - 2'd1;
                    end
                end
                default: state_reg <= BOSTA;
            endcase
        end
    end

    // Completion decode: a write finishes in ERISIM, a read when the count hits zero
    always_comb begin
        yaz_bitti = (state_reg == ERISIM) && yaz_reg;
        oku_bitti = (state_reg == YANIT) && (sayac_reg == 2'd0);
    end

    assign bellek_adres    = adres_reg;
    assign bellek_yaz      = yaz_bitti;
    assign bellek_yaz_veri = yaz_veri_reg;

    // Per-requester completion pulse and read-data hold register
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_istekci
            logic [VERI_BIT-1:0] oku_veri_reg;
            logic                benim;

            assign benim         = (owner_reg == 1'(gi));
            assign bitti_vec[gi] = (yaz_bitti || oku_bitti) && benim;

            // Capture the memory word on this requester's read completion
            always_ff @(posedge clk) begin
                if (rst) begin
                    oku_veri_reg <= '0;
                end else if (oku_bitti && benim) begin
                    oku_veri_reg <= bellek_oku_veri;
                end
            end

            // Memory data goes straight through in the completion cycle
            assign oku_veri_arr[gi] = (oku_bitti && benim) ? bellek_oku_veri : oku_veri_reg;
        end
    endgenerate

    assign i0_bitti    = bitti_vec[0];
    assign i1_bitti    = bitti_vec[1];
    assign i0_oku_veri = oku_veri_arr[0];
    assign i1_oku_veri = oku_veri_arr[1];

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi: one instance with read latency 1 and a
// small word memory, one with latency 3 and a memory returning ~address.
module tb_bellek_hakemi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance with OKU_GECIKME = 1 ----------------
    logic        rst;
    logic        i0_istek, i0_yaz, i0_bitti;
    logic [31:0] i0_adres, i0_yaz_veri, i0_oku_veri;
    logic        i1_istek, i1_yaz, i1_bitti;
    logic [31:0] i1_adres, i1_yaz_veri, i1_oku_veri;
    logic [31:0] bellek_adres, bellek_yaz_veri, bellek_oku_veri;
    logic        bellek_yaz;

    bellek_hakemi #(.OKU_GECIKME(1)) u_dut (
        .clk(clk), .rst(rst),
        .i0_istek(i0_istek), .i0_adres(i0_adres), .i0_yaz(i0_yaz), .i0_yaz_veri(i0_yaz_veri),
        .i0_bitti(i0_bitti), .i0_oku_veri(i0_oku_veri),
        .i1_istek(i1_istek), .i1_adres(i1_adres), .i1_yaz(i1_yaz), .i1_yaz_veri(i1_yaz_veri),
        .i1_bitti(i1_bitti), .i1_oku_veri(i1_oku_veri),
        .bellek_adres(bellek_adres), .bellek_yaz(bellek_yaz),
        .bellek_yaz_veri(bellek_yaz_veri), .bellek_oku_veri(bellek_oku_veri)
    );

    logic [31:0] mem [256];
    logic [31:0] rd_reg;
    assign bellek_oku_veri = rd_reg;

    // Word memory, one-cycle read latency
    always @(posedge clk) begin
        rd_reg <= mem[bellek_adres[9:2]];
        if (bellek_yaz) mem[bellek_adres[9:2]] <= bellek_yaz_veri;
    end

    // ---------------- instance with OKU_GECIKME = 3 ----------------
    logic        rst3;
    logic        d3_i0_istek, d3_i0_bitti;
    logic [31:0] d3_i0_adres, d3_i0_oku_veri;
    logic        d3_i1_istek, d3_i1_bitti;
    logic [31:0] d3_i1_adres, d3_i1_oku_veri;
    logic [31:0] d3_bellek_adres, d3_bellek_yaz_veri, d3_bellek_oku_veri;
    logic        d3_bellek_yaz;
    logic [31:0] d3_pipe [3];
    logic [31:0] sifir32 = 32'h0;
    logic        sifir1  = 1'b0;

    bellek_hakemi #(.OKU_GECIKME(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .i0_istek(d3_i0_istek), .i0_adres(d3_i0_adres), .i0_yaz(sifir1), .i0_yaz_veri(sifir32),
        .i0_bitti(d3_i0_bitti), .i0_oku_veri(d3_i0_oku_veri),
        .i1_istek(d3_i1_istek), .i1_adres(d3_i1_adres), .i1_yaz(sifir1), .i1_yaz_veri(sifir32),
        .i1_bitti(d3_i1_bitti), .i1_oku_veri(d3_i1_oku_veri),
        .bellek_adres(d3_bellek_adres), .bellek_yaz(d3_bellek_yaz),
        .bellek_yaz_veri(d3_bellek_yaz_veri), .bellek_oku_veri(d3_bellek_oku_veri)
    );

    // Memory returning ~address after three cycles
    always @(posedge clk) begin
        d3_pipe[0] <= ~d3_bellek_adres;
        d3_pipe[1] <= d3_pipe[0];
        d3_pipe[2] <= d3_pipe[1];
    end
    assign d3_bellek_oku_veri = d3_pipe[2];

    // ---------------- checking helpers ----------------
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h0000_0513;
        mem[128] = 32'h0000_0BAD;

        rst = 1'b1; rst3 = 1'b1;
        i0_istek = 0; i0_yaz = 0; i0_adres = 0; i0_yaz_veri = 0;
        i1_istek = 0; i1_yaz = 0; i1_adres = 0; i1_yaz_veri = 0;
        d3_i0_istek = 0; d3_i0_adres = 0; d3_i1_istek = 0; d3_i1_adres = 0;
        tick(); tick();

        // Reset state
        chk32("rst_adres", bellek_adres, 32'h8000_0000);
        chk1 ("rst_yaz", bellek_yaz, 1'b0);
        chk32("rst_yaz_veri", bellek_yaz_veri, 32'h0);
        chk1 ("rst_i0_bitti", i0_bitti, 1'b0);
        chk1 ("rst_i1_bitti", i1_bitti, 1'b0);
        chk32("rst_i0_oku", i0_oku_veri, 32'h0);
        chk32("rst_i1_oku", i1_oku_veri, 32'h0);
        chk32("rst3_adres", d3_bellek_adres, 32'h8000_0000);
        $display("[TB] reset state checked");
        rst = 1'b0; rst3 = 1'b0;

        // i0 read of 0x8000_0000 (cycle N)
        i0_istek = 1; i0_adres = 32'h8000_0000; i0_yaz = 0;
        tick();
        chk32("t1_adres_n1", bellek_adres, 32'h8000_0000);
        chk1 ("t1_yaz_n1", bellek_yaz, 1'b0);
        chk1 ("t1_bitti_n1", i0_bitti, 1'b0);
        tick();
        chk1 ("t1_bitti_n2", i0_bitti, 1'b1);
        chk32("t1_oku_n2", i0_oku_veri, 32'h0000_0513);
        chk1 ("t1_i1_bitti", i1_bitti, 1'b0);
        i0_istek = 0;
        tick();
        chk1 ("t1_bitti_n3", i0_bitti, 1'b0);
        chk32("t1_oku_hold", i0_oku_veri, 32'h0000_0513);
        $display("[TB] i0 read 80000000 -> %h", i0_oku_veri);

        // i1 write 0xDEADBEEF to 0x8000_0100
        i1_istek = 1; i1_adres = 32'h8000_0100; i1_yaz = 1; i1_yaz_veri = 32'hDEAD_BEEF;
        chk1 ("t2_yaz_n0", bellek_yaz, 1'b0);
        tick();
        chk1 ("t2_yaz_n1", bellek_yaz, 1'b1);
        chk32("t2_adres_n1", bellek_adres, 32'h8000_0100);
        chk32("t2_veri_n1", bellek_yaz_veri, 32'hDEAD_BEEF);
        chk1 ("t2_i1_bitti_n1", i1_bitti, 1'b1);
        chk1 ("t2_i0_bitti_n1", i0_bitti, 1'b0);
        i1_istek = 0; i1_yaz = 0;
        tick();
        chk1 ("t2_yaz_n2", bellek_yaz, 1'b0);
        chk1 ("t2_i1_bitti_n2", i1_bitti, 1'b0);
        chk32("t2_adres_hold", bellek_adres, 32'h8000_0100);
        // readback by i0
        i0_istek = 1; i0_adres = 32'h8000_0100;
        tick();
        chk1 ("t2_rb_bitti_n1", i0_bitti, 1'b0);
        tick();
        chk1 ("t2_rb_bitti_n2", i0_bitti, 1'b1);
        chk32("t2_rb_oku", i0_oku_veri, 32'hDEAD_BEEF);
        i0_istek = 0;
        $display("[TB] i1 write DEADBEEF, i0 readback %h", i0_oku_veri);
        tick();

        // i1 changes its address after the grant
        i1_istek = 1; i1_adres = 32'h8000_0100; i1_yaz = 0;
        tick();
        i1_adres = 32'h8000_0200;
        chk32("t6_adres_n1", bellek_adres, 32'h8000_0100);
        tick();
        chk32("t6_adres_n2", bellek_adres, 32'h8000_0100);
        chk1 ("t6_bitti", i1_bitti, 1'b1);
        chk32("t6_oku", i1_oku_veri, 32'hDEAD_BEEF);
        i1_istek = 0;
        $display("[TB] i1 late address change, read %h", i1_oku_veri);

        // Both requesters reading continuously from reset: i0,i1 alternate
        rst = 1; i0_istek = 1; i0_adres = 32'h8000_0000; i1_istek = 1; i1_adres = 32'h8000_0100;
        tick(); tick();
        rst = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk1("rr_i0_bitti", i0_bitti, (k % 6) == 2);
            chk1("rr_i1_bitti", i1_bitti, (k % 6) == 5);
            if ((k % 6) == 2) chk32("rr_i0_oku", i0_oku_veri, 32'h0000_0513);
            if ((k % 6) == 5) chk32("rr_i1_oku", i1_oku_veri, 32'hDEAD_BEEF);
            $display("[TB] rr cycle %0d i0_bitti=%b i1_bitti=%b", k, i0_bitti, i1_bitti);
        end
        rst = 1; i0_istek = 0; i1_istek = 0;
        tick();
        rst = 0;

        // Latency 3: i0 read of 0x8000_0010
        d3_i0_istek = 1; d3_i0_adres = 32'h8000_0010;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk32("l3_adres", d3_bellek_adres, 32'h8000_0010);
            chk1 ("l3_yaz", d3_bellek_yaz, 1'b0);
            chk1 ("l3_bitti", d3_i0_bitti, k == 4);
        end
        chk32("l3_oku", d3_i0_oku_veri, 32'h7FFF_FFEF);
        $display("[TB] latency-3 read 80000010 -> %h", d3_i0_oku_veri);
        d3_i0_istek = 0;
        tick();

        // Reset during YANIT of an i1 read, i0 pending afterwards
        d3_i1_istek = 1; d3_i1_adres = 32'h8000_0100;
        tick();                                 // ERISIM
        tick();                                 // first YANIT cycle
        chk1("rm_i1_bitti_y", d3_i1_bitti, 1'b0);
        rst3 = 1; d3_i0_istek = 1; d3_i0_adres = 32'h8000_0040;
        tick();                                 // BOSTA after reset
        chk1 ("rm_i1_bitti_r", d3_i1_bitti, 1'b0);
        chk32("rm_adres_r", d3_bellek_adres, 32'h8000_0000);
        chk1 ("rm_yaz_r", d3_bellek_yaz, 1'b0);
        rst3 = 0;
        tick();                                 // ERISIM for i0
        chk32("rm_grant_i0", d3_bellek_adres, 32'h8000_0040);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk1("rm_i1_quiet", d3_i1_bitti, 1'b0);
            chk1("rm_i0_bitti", d3_i0_bitti, k == 4);
        end
        chk32("rm_i0_oku", d3_i0_oku_veri, 32'h7FFF_FFBF);
        $display("[TB] reset mid-read, i0 then read %h", d3_i0_oku_veri);
        d3_i0_istek = 0; d3_i1_istek = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bellek_hakemi.md
Name: bellek_hakemi

Overview:
- Arbiter that shares the single processor memory port between two requesters.
- Requester 0 (i0): the multi-cycle core. Requester 1 (i1): the program loader/debug DMA.
- Round-robin grant, one transaction at a time, fixed read latency to memory.
- Sits between the requesters and the memory model; the core keeps its request/address stable until it receives `bitti`.

Parameters:
- ADRES_BIT, 32, address width
- VERI_BIT, 32, data width
- OKU_GECIKME, 1, memory read latency in cycles; legal range 1..3
- SIFIR_ADRES, 32'h8000_0000, value of `bellek_adres` after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i0_istek  in  1  requester 0 transaction request; held until `i0_bitti`
- i0_adres  in  ADRES_BIT  requester 0 address
- i0_yaz  in  1  requester 0: 1 = write, 0 = read
- i0_yaz_veri  in  VERI_BIT  requester 0 write data
- i0_bitti  out  1  requester 0 transaction complete, one-cycle pulse
- i0_oku_veri  out  VERI_BIT  requester 0 read data, valid when `i0_bitti` is high on a read
- i1_istek, i1_adres, i1_yaz, i1_yaz_veri, i1_bitti, i1_oku_veri  same as i0, for requester 1
- bellek_adres  out  ADRES_BIT  memory address
- bellek_yaz  out  1  memory write strobe
- bellek_yaz_veri  out  VERI_BIT  memory write data
- bellek_oku_veri  in  VERI_BIT  memory read data, valid OKU_GECIKME cycles after address

Behaviour:
- Reset:
  - state BOSTA, owner = 0, last_grant = 1 (so i0 wins the first tie).
  - `bellek_adres` = SIFIR_ADRES, `bellek_yaz` = 0, `bellek_yaz_veri` = 0.
  - Both `bitti` = 0; both `oku_veri` = 0.
- BOSTA:
  - Sample both `istek`. If none are high, stay in BOSTA.
  - If exactly one is high, grant it.
  - If both are high, grant the requester that is not `last_grant`.
  - On grant, register `adres`/`yaz`/`yaz_veri`/owner, update `last_grant`, and go to ERISIM.
- ERISIM (1 cycle):
  - Drive `bellek_adres`/`bellek_yaz_veri` from the latched values. `bellek_yaz` = latched `yaz`.
  - Write: owner `bitti` = 1 this cycle, then BOSTA.
  - Read: load counter = OKU_GECIKME-1, then YANIT.
- YANIT:
  - Hold `bellek_adres`; `bellek_yaz` = 0.
  - While counter != 0, decrement.
  - When counter = 0: owner `bitti` = 1, owner `oku_veri` = `bellek_oku_veri` (combinational route), next state BOSTA.
- `bitti` is a decode of state and owner. The non-owner's `bitti` is always 0.
- `oku_veri` for a requester holds its last value when not completing.
- Latency from request sampled in BOSTA at cycle N:
  - Write: `bitti` at N+1.
  - Read: `bitti` at N+1+OKU_GECIKME.
- After every completion the arbiter spends one BOSTA cycle. A master streaming back-to-back therefore cannot starve the other; they alternate under contention.
- A requester that drops `istek` mid-transaction does not abort it. The transaction completes and `bitti` still pulses. This is illegal stimulus, but the behaviour is defined.
- Inputs changing after the grant are ignored (latched copy is used).
- `istek` of the owner still high in the completion cycle is not a new request. It is resampled in the following BOSTA cycle.
- `bellek_yaz` is high only in ERISIM of a write, exactly one cycle per write.
- Reset mid-transaction aborts immediately. `bellek_yaz` = 0 from the cycle after the rst edge, and no `bitti` is issued.
- `bellek_adres` holds its last value in BOSTA (no toggling when idle).

Decomposition:
- Shared package holds:
  - state encoding: BOSTA = 2'd0, ERISIM = 2'd1, YANIT = 2'd2
  - requester index constants: I0 = 1'b0, I1 = 1'b1
  - ADRES_BIT/VERI_BIT/SIFIR_ADRES constants
- Sub-module `hakem_oncelik`: combinational 2-way round-robin selector.
  - Inputs: istek[1:0], last_grant.
  - Outputs: gecerli, secilen.
- FSM, latches and counter live in the top module.

Test Plan:
- Reset, then i0 read of 0x8000_0000 with memory returning 0x0000_0513 → `bellek_adres` = 0x8000_0000 at N+1; `i0_bitti` and `i0_oku_veri` = 0x0000_0513 at N+2; `i1_bitti` stays 0.
- i1 write 0xDEADBEEF to 0x8000_0100 → `bellek_yaz` = 1 only at N+1 with address/data matching; `i1_bitti` pulses at N+1; memory readback by i0 returns 0xDEADBEEF.
- i0 and i1 both reading continuously from reset → grants alternate i0, i1, i0, i1; each `bitti` is exactly one cycle wide; no cycle has both `bitti` high.
- OKU_GECIKME = 3, i0 read → `bitti` at N+4; `bellek_adres` held constant N+1..N+4; `bellek_yaz` = 0 throughout.
- rst asserted during YANIT of an i1 read → no `i1_bitti`; after release, state BOSTA, `bellek_adres` = 0x8000_0000; a pending i0 request is granted first.
- i1 changes `i1_adres` to 0x8000_0200 one cycle after grant of 0x8000_0100 → memory sees 0x8000_0100 only.
